comparador_seq: RTL and testbench

COMPARADOR_SEQ -- requirements
Module: comparador_seq

---
 rtl/comparador_pkg.sv | 15 +
 rtl/comparador_seq_if.sv | 25 ++
 rtl/comparador_8bit.sv | 10 +
 rtl/comparador_seq.sv | 103 ++++++++++
 tb/tb_comparador_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/comparador_pkg.sv
// Shared types and constants for the sequential byte-wise comparator.
package comparador_pkg;

  localparam int unsigned NUM_BYTES_DEF = 4;

  localparam logic OP_BEQ = 1'b0;
  localparam logic OP_BNE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } state_t;

endpackage

// File: rtl/comparador_seq_if.sv
// Request/result bundle between a branch unit and comparador_seq.
interface comparador_seq_if #(
  parameter int unsigned W = 32
);

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         igual;
  logic         taken;

  modport master (
    output start, op, a, b,
    input  busy, done, igual, taken
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, igual, taken
  );

endinterface

// File: rtl/comparador_8bit.sv
// Single-byte equality comparator shared by the sequential compare.
module comparador_8bit (
  output logic       igual,
  input  logic [7:0] A,
  input  logic [7:0] B
);

  assign igual = (A == B);

endmodule

// File: rtl/comparador_seq.sv
// Multi-cycle BEQ/BNE evaluator: walks the operands one byte at a time from the
// LSB through a single 8-bit comparator and stops at the first mismatching byte.
module comparador_seq
  import comparador_pkg::*;
#(
  parameter int unsigned NUM_BYTES = NUM_BYTES_DEF,
  parameter int unsigned W         = 8 * NUM_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  comparador_seq_if.slave        bus
);

  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             op_q;
  logic [IDX_W-1:0] idx;
  logic [7:0]       byte_a;
  logic [7:0]       byte_b;
  logic             byte_eq;
  logic             busy_d;
  logic             done_d;
  logic             load;
  logic             advance;
  logic             finish;

  // Byte lane selected by idx from the latched operands.
  assign byte_a = a_q[{idx, 3'b000} +: 8];
  assign byte_b = b_q[{idx, 3'b000} +: 8];

  comparador_8bit u_cmp (
    .igual (byte_eq),
    .A     (byte_a),
    .B     (byte_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = COMPARA;
      COMPARA: if (!byte_eq || (idx == IDX_LAST)) state_next = FIM;
      FIM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are computed from the next state so they register with it.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    busy_d  = (state_next != IDLE);
    done_d  = (state_next == FIM);
    load    = (state == IDLE) && bus.start;
    advance = (state == COMPARA) && byte_eq && (idx != IDX_LAST);
    finish  = (state == COMPARA) && (state_next == FIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      idx       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.igual <= 1'b0;
      bus.taken <= 1'b0;
    end else begin
      bus.busy <= busy_d;
      bus.done <= done_d;
      if (load) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.op;
        idx  <= '0;
      end else if (advance) begin
        idx <= idx + IDX_W'(1);
      end
      // A finish on a matching byte can only be the last byte, so byte_eq is the verdict.
      if (finish) begin
        bus.igual <= byte_eq;
        bus.taken <= byte_eq ? (op_q == OP_BEQ) : (op_q == OP_BNE);
      end
    end
  end

endmodule

// File: tb/tb_comparador_seq.sv
// Directed and randomized checks of comparador_seq against a byte-scan reference model.
module tb_comparador_seq;
  import comparador_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  comparador_seq_if #(.W(W)) bus ();

  comparador_seq #(.NUM_BYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: bytes examined = position of first differing byte (LSB first), else all.
  function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic top, output int m,
                                output logic ei, output logic et);
    logic [W-1:0] diff;
    diff = ta ^ tb;
    ei   = (ta == tb);
    et   = ei ^ top;
    m    = NB;
    for (int i = NB - 1; i >= 0; i--) begin
      if (diff[8*i +: 8] != 8'h00) m = i + 1;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after FIM.
  task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                        input string tag, input bit hold, input bit repulse);
    int   m;
    int   lat;
    logic ei;
    logic et;
    logic gi;
    logic gt;
    model(ta, tb, top, m, ei, et);
    bus.a     = ta;
    bus.b     = tb;
    bus.op    = top;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.a  = W'($urandom);
    bus.b  = W'($urandom);
    bus.op = 1'($urandom);
    @(negedge clk);
    chk({tag, "_busy_after_accept"}, int'(bus.busy), 1);
    lat = -1;
    gi  = 1'bx;
    gt  = 1'bx;
    for (int c = 0; c <= int'(NB) + 2; c++) begin
      if (c > 0) @(negedge clk);
      if (repulse && c == 1) begin
        bus.start = 1'b1;
        bus.a     = '0;
      end
      if (repulse && c == 2) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = c;
        gi  = bus.igual;
        gt  = bus.taken;
        break;
      end
    end
    chk({tag, "_latency"}, lat, m);
    chk({tag, "_igual"}, int'(gi), int'(ei));
    chk({tag, "_taken"}, int'(gt), int'(et));
    @(negedge clk);
    chk({tag, "_idle_gap_busy"}, int'(bus.busy), 0);
    chk({tag, "_idle_gap_done"}, int'(bus.done), 0);
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_stays_idle"}, int'(bus.busy), 0);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;
    int           sel;
    int           npulse;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = OP_BEQ;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'hDEADBEEF;

    // Reset holds off a pending start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_igual", int'(bus.igual), 0);
    chk("reset_taken", int'(bus.taken), 0);

    // First edge with rst low accepts: full match, BEQ.
    rst = 1'b0;
    do_cmp(32'hDEADBEEF, 32'hDEADBEEF, OP_BEQ, "full_match", 1'b0, 1'b0);
    do_cmp(32'h00000004, 32'h00000005, OP_BNE, "early_exit", 1'b0, 1'b0);
    do_cmp(32'h10000004, 32'h20000004, OP_BEQ, "top_byte", 1'b0, 1'b0);
    do_cmp(32'h12345678, 32'h12345678, OP_BEQ, "start_busy", 1'b0, 1'b1);

    // Reset in the second COMPARA cycle aborts without a done pulse.
    bus.a     = 32'h0F0F0F0F;
    bus.b     = 32'h0F0F0F0F;
    bus.op    = OP_BEQ;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_igual", int'(bus.igual), 0);
    chk("midrst_taken", int'(bus.taken), 0);
    npulse = 0;
    for (int c = 0; c < int'(NB) + 3; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) npulse++;
    end
    chk("midrst_no_done", npulse, 0);

    // Back-to-back with start held through FIM.
    do_cmp(32'h04040404, 32'h04040404, OP_BEQ, "b2b_first", 1'b1, 1'b0);
    do_cmp(32'h04040404, 32'h04040405, OP_BEQ, "b2b_second", 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra  = W'($urandom);
      rop = 1'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: begin
          rb  = ra;
          sel = int'($urandom_range(0, NB - 1));
          rb[8*sel +: 8] = ~ra[8*sel +: 8];
        end
        default: rb = W'($urandom);
      endcase
      do_cmp(ra, rb, rop, $sformatf("rnd%0d", n), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
